// File: rtl/gnrl_fifo.sv
// gnrl_fifo: single-clock valid/ready FIFO built from DP register entries.
// Occupancy is tracked in an explicit counter; full/empty come from it, so
// any depth 1..64 works without power-of-two pointer tricks.
module gnrl_fifo #(
  parameter int unsigned DP        = 4,
  parameter int unsigned DW        = 32,
  parameter bit          CUT_READY = 1'b0,
  parameter bit          MSKO      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  output logic                    i_rdy,
  input  logic [DW-1:0]           i_dat,
  output logic                    o_vld,
  input  logic                    o_rdy,
  output logic [DW-1:0]           o_dat,
  output logic [$clog2(DP+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DP + 1);
  // A depth-1 FIFO still needs a 1-bit pointer to keep the vectors legal.
  localparam int unsigned PtrW = (DP > 1) ? $clog2(DP) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DP);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DP - 1);

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [DW-1:0]   mem_q [DP];
  logic [DP-1:0]   we;

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);
  assign count = count_q;

  // Handshake decode: ready either looks through to o_rdy or only at state.
  always_comb begin
    if (CUT_READY) begin
      i_rdy = !full;
    end else begin
      i_rdy = !full || o_rdy;
    end
    o_vld = !empty;
    push  = i_vld && i_rdy;
    pop   = !empty && o_rdy;
  end

  // Next-state for pointers (wrap at DP-1) and occupancy.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Per-entry load enable: only the slot under the write pointer captures.
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      we[i] = push && !rst && (wptr_q == PtrW'(i));
    end
  end

  // Data storage; deliberately not reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DP; i++) begin
      if (we[i]) begin
        mem_q[i] <= i_dat;
      end
    end
  end

  // Head entry read straight from state, optionally zeroed when empty.
  always_comb begin
    o_dat = mem_q[rptr_q];
    if (MSKO && empty) begin
      o_dat = '0;
    end
  end

endmodule

// File: tb/tb_gnrl_fifo.sv
// tb_gnrl_fifo: directed vector tables, a DP=3 streaming run and a randomized
// run of eight depth/ready-mode combinations against a queue model.
module tb_gnrl_fifo;

  localparam int NI = 11;

  // Instance map: 0..3 DP={1,2,5,8} CUT_READY=0, 4..7 same with CUT_READY=1,
  // 8 DP=4 CUT_READY=0 MSKO=1, 9 DP=4 CUT_READY=1, 10 DP=3 CUT_READY=0.
  function automatic int unsigned dp_of(input int i);
    case (i)
      0, 4:    return 1;
      1, 5:    return 2;
      2, 6:    return 5;
      3, 7:    return 8;
      8, 9:    return 4;
      default: return 3;
    endcase
  endfunction

  function automatic bit cr_of(input int i);
    return (i >= 4 && i <= 7) || (i == 9);
  endfunction

  function automatic bit ms_of(input int i);
    return i == 8;
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] ivld, irdy, ovld, ordy;
  logic [31:0]   idat [NI];
  logic [31:0]   odat [NI];
  logic [6:0]    cnt  [NI];

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned GDP = dp_of(g);
    localparam bit          GCR = cr_of(g);
    localparam bit          GMS = ms_of(g);
    logic [$clog2(GDP+1)-1:0] c;

    gnrl_fifo #(
      .DP       (GDP),
      .DW       (32),
      .CUT_READY(GCR),
      .MSKO     (GMS)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .i_vld(ivld[g]),
      .i_rdy(irdy[g]),
      .i_dat(idat[g]),
      .o_vld(ovld[g]),
      .o_rdy(ordy[g]),
      .o_dat(odat[g]),
      .count(c)
    );
    assign cnt[g] = 7'(c);

    // Producer must hold a stalled offer.
    ap_hold: assert property (@(posedge clk) disable iff (rst)
      (ivld[g] && !irdy[g]) |=> (ivld[g] && $stable(idat[g])));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          inst;
    logic        rst;
    logic        vld;
    logic [31:0] dat;
    logic        rdy;
    logic        e_irdy;
    logic        e_ovld;
    logic [31:0] e_dat;
    int          e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int inst, input logic r, input logic v, input logic [31:0] d,
                     input logic rd, input logic ei, input logic eo, input logic [31:0] ed,
                     input int ec);
    vec_t x;
    x.inst = inst; x.rst = r; x.vld = v; x.dat = d; x.rdy = rd;
    x.e_irdy = ei; x.e_ovld = eo; x.e_dat = ed; x.e_cnt = ec;
    vt.push_back(x);
  endtask

  // Reference model for the randomized instances: one queue per FIFO.
  logic [31:0] mq [8][$];
  logic [7:0]  hold;
  logic [7:0]  push_m, pop_m;
  int          vpct [4] = '{50, 85, 30, 70};
  int          rpct [4] = '{50, 30, 85, 70};

  initial begin
    rst  = 1'b1;
    ivld = '0;
    ordy = '0;
    hold = '0;
    for (int i = 0; i < NI; i++) idat[i] = '0;

    // Instance 8: DP=4, CUT_READY=0, MSKO=1. Outputs are seen before the edge.
    for (int i = 0; i < 3; i++) add(8, 0, 0, 0, 0, 1, 0, 0, 0);
    add(8, 0, 1, 'h11, 0, 1, 0, 0,     0);
    add(8, 0, 1, 'h22, 0, 1, 1, 'h11,  1);
    add(8, 0, 1, 'h33, 0, 1, 1, 'h11,  2);
    add(8, 0, 1, 'h44, 0, 1, 1, 'h11,  3);
    add(8, 0, 0, 0,    0, 0, 1, 'h11,  4);
    add(8, 0, 1, 'h55, 1, 1, 1, 'h11,  4);
    add(8, 0, 0, 0,    1, 1, 1, 'h22,  4);
    add(8, 0, 0, 0,    1, 1, 1, 'h33,  3);
    add(8, 0, 0, 0,    1, 1, 1, 'h44,  2);
    add(8, 0, 0, 0,    1, 1, 1, 'h55,  1);
    add(8, 0, 0, 0,    0, 1, 0, 0,     0);
    add(8, 0, 1, 'h66, 1, 1, 0, 0,     0);
    add(8, 0, 0, 0,    1, 1, 1, 'h66,  1);
    add(8, 0, 0, 0,    0, 1, 0, 0,     0);
    add(8, 0, 1, 'h71, 0, 1, 0, 0,     0);
    add(8, 0, 1, 'h72, 0, 1, 1, 'h71,  1);
    add(8, 0, 1, 'h73, 0, 1, 1, 'h71,  2);
    add(8, 1, 1, 'h74, 1, 1, 1, 'h71,  3);
    add(8, 0, 0, 0,    0, 1, 0, 0,     0);
    add(8, 0, 1, 'hAB, 0, 1, 0, 0,     0);
    add(8, 0, 0, 0,    1, 1, 1, 'hAB,  1);
    add(8, 0, 0, 0,    0, 1, 0, 0,     0);
    // Instance 9: DP=4, CUT_READY=1; 0x55 is held until a slot frees up.
    add(9, 0, 0, 0,    0, 1, 0, 0,     0);
    add(9, 0, 1, 'h11, 0, 1, 0, 0,     0);
    add(9, 0, 1, 'h22, 0, 1, 1, 'h11,  1);
    add(9, 0, 1, 'h33, 0, 1, 1, 'h11,  2);
    add(9, 0, 1, 'h44, 0, 1, 1, 'h11,  3);
    add(9, 0, 1, 'h55, 0, 0, 1, 'h11,  4);
    add(9, 0, 1, 'h55, 0, 0, 1, 'h11,  4);
    add(9, 0, 1, 'h55, 1, 0, 1, 'h11,  4);
    add(9, 0, 1, 'h55, 0, 1, 1, 'h22,  3);
    add(9, 0, 0, 0,    1, 0, 1, 'h22,  4);
    add(9, 0, 0, 0,    1, 1, 1, 'h33,  3);
    add(9, 0, 0, 0,    1, 1, 1, 'h44,  2);
    add(9, 0, 0, 0,    1, 1, 1, 'h55,  1);
    add(9, 0, 0, 0,    0, 1, 0, 0,     0);

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset_irdy_u%0d", g), 64'(irdy[g]), 64'd1);
      check($sformatf("reset_ovld_u%0d", g), 64'(ovld[g]), 64'd0);
      check($sformatf("reset_cnt_u%0d", g), 64'(cnt[g]), 64'd0);
    end
    check("reset_odat_masked", 64'(odat[8]), 64'd0);
    rst = 1'b0;

    // Table-driven directed sequences.
    for (int n = 0; n < vt.size(); n++) begin
      rst     = vt[n].rst;
      ivld[8] = 1'b0; ordy[8] = 1'b0; idat[8] = '0;
      ivld[9] = 1'b0; ordy[9] = 1'b0; idat[9] = '0;
      ivld[vt[n].inst] = vt[n].vld;
      idat[vt[n].inst] = vt[n].dat;
      ordy[vt[n].inst] = vt[n].rdy;
      #1;
      check($sformatf("vec%0d_u%0d_irdy", n, vt[n].inst), 64'(irdy[vt[n].inst]),
            64'(vt[n].e_irdy));
      check($sformatf("vec%0d_u%0d_ovld", n, vt[n].inst), 64'(ovld[vt[n].inst]),
            64'(vt[n].e_ovld));
      check($sformatf("vec%0d_u%0d_cnt", n, vt[n].inst), 64'(cnt[vt[n].inst]),
            64'(vt[n].e_cnt));
      if (vt[n].e_ovld || ms_of(vt[n].inst)) begin
        check($sformatf("vec%0d_u%0d_odat", n, vt[n].inst), 64'(odat[vt[n].inst]),
              64'(vt[n].e_dat));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    ivld[8] = 1'b0; ordy[8] = 1'b0;
    ivld[9] = 1'b0; ordy[9] = 1'b0;

    // Streaming through DP=3: one-cycle latency, occupancy pinned at 1.
    for (int k = 0; k < 20; k++) begin
      ivld[10] = 1'b1;
      idat[10] = 32'(100 + k);
      ordy[10] = 1'b1;
      #1;
      check($sformatf("stream%0d_irdy", k), 64'(irdy[10]), 64'd1);
      if (k == 0) begin
        check("stream0_ovld", 64'(ovld[10]), 64'd0);
        check("stream0_cnt", 64'(cnt[10]), 64'd0);
      end else begin
        check($sformatf("stream%0d_ovld", k), 64'(ovld[10]), 64'd1);
        check($sformatf("stream%0d_odat", k), 64'(odat[10]), 64'(99 + k));
        check($sformatf("stream%0d_cnt", k), 64'(cnt[10]), 64'd1);
      end
      @(posedge clk);
      #1;
    end
    ivld[10] = 1'b0;
    #1;
    check("stream_tail_odat", 64'(odat[10]), 64'd119);
    check("stream_tail_cnt", 64'(cnt[10]), 64'd1);
    @(posedge clk);
    #1;
    check("stream_end_ovld", 64'(ovld[10]), 64'd0);
    check("stream_end_cnt", 64'(cnt[10]), 64'd0);
    ordy[10] = 1'b0;

    // Randomized traffic on instances 0..7 against the queue model.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int ph;
      ph = (cyc / 250) % 4;
      for (int g = 0; g < 8; g++) begin
        if (!hold[g]) begin
          ivld[g] = ($urandom_range(0, 99) < vpct[ph]);
          idat[g] = $urandom();
        end
        ordy[g] = ($urandom_range(0, 99) < rpct[ph]);
      end
      #1;
      for (int g = 0; g < 8; g++) begin
        int unsigned sz;
        logic        e_ovld, e_irdy;
        logic [31:0] e_dat;
        sz     = mq[g].size();
        e_ovld = (sz != 0);
        e_irdy = cr_of(g) ? (sz < dp_of(g)) : ((sz < dp_of(g)) || ordy[g]);
        e_dat  = e_ovld ? mq[g][0] : 32'h0;
        check($sformatf("rand_c%0d_u%0d {ovld,irdy,cnt,odat}", cyc, g),
              64'({ovld[g], irdy[g], cnt[g], (e_ovld ? odat[g] : 32'h0)}),
              64'({e_ovld, e_irdy, 7'(sz), e_dat}));
        push_m[g] = ivld[g] && e_irdy;
        pop_m[g]  = e_ovld && ordy[g];
        hold[g]   = ivld[g] && !irdy[g];
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 8; g++) begin
        if (pop_m[g]) void'(mq[g].pop_front());
        if (push_m[g]) mq[g].push_back(idat[g]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
